// File: rtl/i2s_play_ctrl_pkg.sv
// Shared state encoding for the I2S playback sequencer.
// Used by the FSM and by the top-level status LED decode.
package i2s_play_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_FAULT   = 3'd0,
        ST_RELOCK  = 3'd1,
        ST_PREFILL = 3'd2,
        ST_PLAY    = 3'd3
    } state_e;

endpackage

// File: rtl/i2s_play_ctrl_level.sv
// fifo_level_counter: up/down FIFO occupancy counter.
// Ports: clk, reset (async, active-high), i_clr (sync clear),
//        i_inc / i_dec (one-cycle strobes), o_level, o_full, o_empty.
module fifo_level_counter #(
    parameter int DEPTH   = 8,
    parameter int LEVEL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clr,
    input  logic               i_inc,
    input  logic               i_dec,
    output logic [LEVEL_W-1:0] o_level,
    output logic               o_full,
    output logic               o_empty
);

    logic [LEVEL_W-1:0] r_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= '0;
        end else if (i_clr) begin
            r_level <= '0;
        end else if (i_inc && !i_dec) begin
            r_level <= r_level + 1'b1;
        end else if (i_dec && !i_inc) begin
            r_level <= r_level - 1'b1;
        end
    end

    assign o_level = r_level;
    assign o_full  = (r_level == LEVEL_W'(DEPTH));
    assign o_empty = (r_level == '0);

endmodule

// File: rtl/i2s_play_ctrl.sv
// i2s_play_ctrl: playback sequencer between the S/PDIF decoder and the
// I2S transmitter, gating the 8-entry sample FIFO and tracking occupancy.
// Ports: clk, reset (async, active-high); in: spdif_write, spdif_fault,
//        next_sample; out: fifo_write, fifo_read (combinational),
//        fifo_flush, mute, level, state, underrun, overrun (registered).
module i2s_play_ctrl
    import i2s_play_ctrl_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int LEVEL_W       = 4,
    parameter int START_LEVEL   = 4,
    parameter int RELOCK_WRITES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               spdif_write,
    input  logic               spdif_fault,
    input  logic               next_sample,
    output logic               fifo_write,
    output logic               fifo_read,
    output logic               fifo_flush,
    output logic               mute,
    output logic [LEVEL_W-1:0] level,
    output logic [STATE_W-1:0] state,
    output logic               underrun,
    output logic               overrun
);

    localparam int CNT_W = $clog2(RELOCK_WRITES);
    localparam logic [CNT_W-1:0] RELOCK_LAST =
        CNT_W'(RELOCK_WRITES - 1);
    localparam logic [LEVEL_W:0] START_L =
        (LEVEL_W + 1)'(START_LEVEL);

    state_e             r_state;
    state_e             w_next;
    logic [CNT_W-1:0]   r_relock_cnt;
    logic               r_mute;
    logic               r_underrun;
    logic               r_overrun;

    logic [LEVEL_W-1:0] w_level;
    logic               w_full;
    logic               w_empty;
    logic               w_wr_req;
    logic               w_wr;
    logic               w_rd;
    logic               w_clr;
    logic               w_under;
    logic               w_drop;

    // Writes are only candidates once the decoder has relocked.
    assign w_wr_req = spdif_write &&
                      (r_state == ST_PREFILL || r_state == ST_PLAY);
    assign w_rd     = (r_state == ST_PLAY) && next_sample && !w_empty;
    // A read in the same cycle frees the slot the write needs.
    assign w_wr     = w_wr_req && (!w_full || w_rd);
    assign w_drop   = w_wr_req && !w_wr;
    assign w_under  = (r_state == ST_PLAY) && next_sample && w_empty;
    // Clear on the entry edge too, so level reads 0 with state FAULT.
    assign w_clr    = (r_state == ST_FAULT) || (w_next == ST_FAULT);

    always_comb begin
        w_next = r_state;
        if (spdif_fault) begin
            w_next = ST_FAULT;
        end else begin
            case (r_state)
                ST_FAULT: begin
                    w_next = ST_RELOCK;
                end
                ST_RELOCK: begin
                    if (spdif_write && r_relock_cnt == RELOCK_LAST) begin
                        w_next = ST_PREFILL;
                    end
                end
                ST_PREFILL: begin
                    if ({1'b0, w_level} >= START_L) begin
                        w_next = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (w_under) begin
                        w_next = ST_PREFILL;
                    end
                end
                default: begin
                    w_next = ST_FAULT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_FAULT;
            r_mute     <= 1'b1;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_mute     <= (w_next != ST_PLAY);
            r_underrun <= w_under;
            r_overrun  <= w_drop;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_relock_cnt <= '0;
        end else if (r_state != ST_RELOCK) begin
            r_relock_cnt <= '0;
        end else if (spdif_write) begin
            r_relock_cnt <= r_relock_cnt + 1'b1;
        end
    end

    fifo_level_counter #(
        .DEPTH   (DEPTH),
        .LEVEL_W (LEVEL_W)
    ) u_level (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_clr),
        .i_inc   (w_wr),
        .i_dec   (w_rd),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign fifo_write = w_wr;
    assign fifo_read  = w_rd;
    assign fifo_flush = (r_state == ST_FAULT);
    assign mute       = r_mute;
    assign level      = w_level;
    assign state      = r_state;
    assign underrun   = r_underrun;
    assign overrun    = r_overrun;

endmodule
